// File: rtl/adder_request_scheduler.sv
// adder_request_scheduler
//   Lets two requesters share one WIDTH-bit adder/subtractor. A round-robin
//   arbiter grants one operation at a time. The FSM drives the latched
//   operands into the shared adder for SETTLE_CYCLES clocks. It then captures
//   the sum, the carry and the negative-sign flag, and presents them on a
//   valid/ready response port.
//
//   Optional feature (macro ADDER_SCHED_MAG_CORRECT_EN):
//     When the macro is defined and a subtraction borrows, Rsp_Result carries
//     the magnitude |A-B| instead of the raw wrapped sum.
//
// Ports
//   Clk, Rst_n                      clock, asynchronous active-low reset
//   Req{0,1}_Valid/_Ready           request handshake per requester
//   Req{0,1}_A/_B/_Sel              operands, Sel=1 selects A-B
//   Adder_A/_B/_Sel                 operands driven to the shared adder
//   Adder_Sum/_Carry_Out            shared adder result
//   Rsp_Valid/_Ready                response handshake
//   Rsp_Id/_Result/_Carry/_Negative response payload
module adder_request_scheduler #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Req0_Valid,
  output logic             Req0_Ready,
  input  logic [WIDTH-1:0] Req0_A,
  input  logic [WIDTH-1:0] Req0_B,
  input  logic             Req0_Sel,
  input  logic             Req1_Valid,
  output logic             Req1_Ready,
  input  logic [WIDTH-1:0] Req1_A,
  input  logic [WIDTH-1:0] Req1_B,
  input  logic             Req1_Sel,
  output logic [WIDTH-1:0] Adder_A,
  output logic [WIDTH-1:0] Adder_B,
  output logic             Adder_Sel,
  input  logic [WIDTH-1:0] Adder_Sum,
  input  logic             Adder_Carry_Out,
  output logic             Rsp_Valid,
  input  logic             Rsp_Ready,
  output logic             Rsp_Id,
  output logic [WIDTH-1:0] Rsp_Result,
  output logic             Rsp_Carry,
  output logic             Rsp_Negative
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             ptr_reg;       // id of the last granted requester
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sel_reg, id_reg;
  logic             rsp_valid_reg, rsp_id_reg, rsp_carry_reg, rsp_neg_reg;
  logic [WIDTH-1:0] rsp_result_reg;

  logic             grant_id, any_valid, accept, capture, rsp_done;
  logic             cap_neg;
  logic [WIDTH-1:0] cap_result;

  // When both requesters are valid, the one not granted last time wins.
  assign any_valid = Req0_Valid | Req1_Valid;
  assign grant_id  = (Req0_Valid & Req1_Valid) ? ~ptr_reg : Req1_Valid;
  assign accept    = (state_reg == IDLE) & any_valid & Rst_n;
  assign capture   = (state_reg == SETTLE) & (cnt_reg == CNT_ONE);
  assign rsp_done  = (state_reg == RESP) & rsp_valid_reg & Rsp_Ready;

  // A subtraction with no carry-out has borrowed, so the result is negative.
  assign cap_neg = sel_reg & ~Adder_Carry_Out;
`ifdef ADDER_SCHED_MAG_CORRECT_EN
  assign cap_result = cap_neg ? (~Adder_Sum + WIDTH'(1)) : Adder_Sum;
`else
  assign cap_result = Adder_Sum;
`endif

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)   state_next = SETTLE;
      SETTLE:  if (capture)  state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. Ready is gated by Rst_n so that every output reads 0 while
  // reset is held, even if requesters keep Valid asserted.
  always_comb begin
    Req0_Ready = 1'b0;
    Req1_Ready = 1'b0;
    Adder_A    = '0;
    Adder_B    = '0;
    Adder_Sel  = 1'b0;
    if (state_reg == IDLE && Rst_n) begin
      Req0_Ready = Req0_Valid & ~grant_id;
      Req1_Ready = Req1_Valid &  grant_id;
    end
    if (state_reg == SETTLE) begin
      Adder_A   = a_reg;
      Adder_B   = b_reg;
      Adder_Sel = sel_reg;
    end
  end

  // Operand latch, settle counter and response registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr_reg        <= 1'b1;
      cnt_reg        <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      sel_reg        <= 1'b0;
      id_reg         <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= '0;
      rsp_carry_reg  <= 1'b0;
      rsp_neg_reg    <= 1'b0;
    end else begin
      if (accept) begin
        a_reg   <= grant_id ? Req1_A   : Req0_A;
        b_reg   <= grant_id ? Req1_B   : Req0_B;
        sel_reg <= grant_id ? Req1_Sel : Req0_Sel;
        id_reg  <= grant_id;
        ptr_reg <= grant_id;
        cnt_reg <= CNT_LOAD;
      end else if (state_reg == SETTLE) begin
        cnt_reg <= cnt_reg - CNT_ONE;
      end
      if (capture) begin
        rsp_valid_reg  <= 1'b1;
        rsp_id_reg     <= id_reg;
        rsp_result_reg <= cap_result;
        rsp_carry_reg  <= Adder_Carry_Out;
        rsp_neg_reg    <= cap_neg;
      end else if (rsp_done) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign Rsp_Valid    = rsp_valid_reg;
  assign Rsp_Id       = rsp_id_reg;
  assign Rsp_Result   = rsp_result_reg;
  assign Rsp_Carry    = rsp_carry_reg;
  assign Rsp_Negative = rsp_neg_reg;

endmodule

// File: tb/tb_adder_request_scheduler.sv
// tb_adder_request_scheduler
//   Drives two requesters into adder_request_scheduler and models the shared
//   adder. A monitor runs on the falling edge. On every accept it pushes the
//   expected response, worked out from plain arithmetic, and it pops and
//   compares that response on every response handshake. The monitor also
//   checks the grant order, the latency, response stability, the adder drive
//   and the outputs during reset.
module tb_adder_request_scheduler;
  localparam int WIDTH = 4;
  localparam int SETTLE_CYCLES = 1;
  localparam int MOD = 1 << WIDTH;

  logic clk, rst_n;
  logic req_v [2];
  logic [WIDTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_b [2];
  logic req_s [2];
  logic Req0_Ready, Req1_Ready;
  logic [WIDTH-1:0] Adder_A, Adder_B, Adder_Sum, Rsp_Result;
  logic Adder_Sel, Adder_Carry_Out;
  logic Rsp_Valid, rsp_ready, Rsp_Id, Rsp_Carry, Rsp_Negative;
  logic [WIDTH:0] adder_full;

  adder_request_scheduler #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .Req0_Valid(req_v[0]), .Req0_Ready(Req0_Ready),
    .Req0_A(req_a[0]), .Req0_B(req_b[0]), .Req0_Sel(req_s[0]),
    .Req1_Valid(req_v[1]), .Req1_Ready(Req1_Ready),
    .Req1_A(req_a[1]), .Req1_B(req_b[1]), .Req1_Sel(req_s[1]),
    .Adder_A(Adder_A), .Adder_B(Adder_B), .Adder_Sel(Adder_Sel),
    .Adder_Sum(Adder_Sum), .Adder_Carry_Out(Adder_Carry_Out),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(rsp_ready), .Rsp_Id(Rsp_Id),
    .Rsp_Result(Rsp_Result), .Rsp_Carry(Rsp_Carry), .Rsp_Negative(Rsp_Negative)
  );

  // Shared adder: A + (Sel ? ~B + 1 : B), carry out of the top bit
  assign adder_full = {1'b0, Adder_A} + {1'b0, (Adder_Sel ? ~Adder_B : Adder_B)}
                      + {{WIDTH{1'b0}}, Adder_Sel};
  assign Adder_Sum = adder_full[WIDTH-1:0];
  assign Adder_Carry_Out = adder_full[WIDTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id; int a; int b; int sel;
    int res; int carry; int neg; int cyc;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int failures = 0;
  int acc_cnt [2] = '{0, 0};
  int seen [2] = '{0, 0};

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic exp_t predict(int id, int a, int b, int sel, int c);
    exp_t e;
    e.id = id; e.a = a; e.b = b; e.sel = sel; e.cyc = c;
    if (sel != 0) begin
      e.res = (a - b + MOD) % MOD;
      e.carry = (a >= b) ? 1 : 0;
      e.neg = (a < b) ? 1 : 0;
`ifdef ADDER_SCHED_MAG_CORRECT_EN
      if (e.neg != 0) e.res = b - a;
`endif
    end else begin
      e.res = (a + b) % MOD;
      e.carry = (a + b >= MOD) ? 1 : 0;
      e.neg = 0;
    end
    return e;
  endfunction

  // Monitor / scoreboard
  int last_id = 1;
  bit settle_pend = 0;
  exp_t pend;
  bit prev_valid = 0, prev_hs = 0;
  int prev_id, prev_res, prev_carry, prev_neg;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs_zero",
            int'({Req0_Ready, Req1_Ready, Adder_A, Adder_B, Adder_Sel,
                  Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Carry, Rsp_Negative}), 0);
      sb.delete();
      last_id = 1;
      settle_pend = 0;
      prev_valid = 0;
      prev_hs = 0;
    end else begin
      if (settle_pend) begin
        check("settle_adder_a", int'(Adder_A), pend.a);
        check("settle_adder_b", int'(Adder_B), pend.b);
        check("settle_adder_sel", int'(Adder_Sel), pend.sel);
        settle_pend = 0;
      end else begin
        check("adder_idle_zero", int'({Adder_A, Adder_B, Adder_Sel}), 0);
      end
      check("single_ready", int'(Req0_Ready & Req1_Ready), 0);
      check("ready0_needs_valid", int'(Req0_Ready & ~req_v[0]), 0);
      check("ready1_needs_valid", int'(Req1_Ready & ~req_v[1]), 0);
      if (Rsp_Valid) check("no_ready_during_rsp", int'(Req0_Ready | Req1_Ready), 0);

      // Response side
      if (Rsp_Valid) begin
        if (!prev_valid) begin
          if (sb.size() == 0) check("unexpected_response", 1, 0);
          else check("latency", cyc - sb[0].cyc, SETTLE_CYCLES + 1);
        end else if (!prev_hs) begin
          check("stable_id", int'(Rsp_Id), prev_id);
          check("stable_result", int'(Rsp_Result), prev_res);
          check("stable_carry", int'(Rsp_Carry), prev_carry);
          check("stable_negative", int'(Rsp_Negative), prev_neg);
        end
        if (rsp_ready && sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_id", int'(Rsp_Id), e.id);
          check("rsp_result", int'(Rsp_Result), e.res);
          check("rsp_carry", int'(Rsp_Carry), e.carry);
          check("rsp_negative", int'(Rsp_Negative), e.neg);
          $display("rsp id=%0d a=%0d b=%0d sel=%0d result=%0d carry=%0d neg=%0d",
                   e.id, e.a, e.b, e.sel, Rsp_Result, Rsp_Carry, Rsp_Negative);
        end
      end else if (prev_valid && !prev_hs) begin
        check("rsp_dropped_without_handshake", 0, 1);
      end
      prev_valid = Rsp_Valid;
      prev_hs = Rsp_Valid & rsp_ready;
      prev_id = int'(Rsp_Id);
      prev_res = int'(Rsp_Result);
      prev_carry = int'(Rsp_Carry);
      prev_neg = int'(Rsp_Negative);

      // Request side: accept happens at the coming rising edge
      for (int i = 0; i < 2; i++) begin
        logic rdy;
        rdy = (i == 0) ? Req0_Ready : Req1_Ready;
        if (req_v[i] && rdy) begin
          int exp_g;
          exp_g = (req_v[0] && req_v[1]) ? 1 - last_id : (req_v[1] ? 1 : 0);
          check("grant_id", i, exp_g);
          pend = predict(i, int'(req_a[i]), int'(req_b[i]), int'(req_s[i]), cyc);
          sb.push_back(pend);
          settle_pend = 1;
          last_id = i;
          acc_cnt[i]++;
        end
      end
    end
  end

  // Stimulus helpers (all start and end at posedge+1)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_op(int i);
    req_a[i] = WIDTH'($urandom_range(0, MOD - 1));
    req_b[i] = WIDTH'($urandom_range(0, MOD - 1));
    req_s[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_acc(int i);
    for (int n = 0; n < 100; n++) begin
      step();
      if (acc_cnt[i] != seen[i]) begin
        seen[i] = acc_cnt[i];
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout: requester %0d got no accept expected within 100 cycles", i);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (sb.size() == 0 && !Rsp_Valid) return;
      step();
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
  endtask

  task automatic do_op(int i, int a, int b, int sel);
    seen[i] = acc_cnt[i];
    req_a[i] = WIDTH'(a);
    req_b[i] = WIDTH'(b);
    req_s[i] = 1'(sel);
    req_v[i] = 1'b1;
    wait_acc(i);
    req_v[i] = 1'b0;
    drain();
  endtask

  // hold=1: both requesters stay valid and responses are always taken
  task automatic run_mix(int cycles, bit hold);
    seen[0] = acc_cnt[0];
    seen[1] = acc_cnt[1];
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          new_op(i);
          req_v[i] = hold ? 1'b1 : 1'($urandom_range(0, 3) != 0);
        end else if (hold) begin
          req_v[i] = 1'b1;
        end else if (!req_v[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            new_op(i);
            req_v[i] = 1'b1;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          req_v[i] = 1'b0;
        end
      end
      rsp_ready = hold ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      step();
    end
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    // Reset with both requesters already valid
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b1;
      new_op(i);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both valid and held: grants alternate 0,1,0,1...
    run_mix(16, 1'b1);
    drain();

    // Directed operations
    do_op(0, 3, 5, 0);
    do_op(1, 3, 5, 1);
    do_op(0, 5, 3, 1);
    do_op(1, 15, 1, 0);
    do_op(0, 0, 0, 1);

    // Response back-pressure, with requester 1 waiting meanwhile
    rsp_ready = 1'b0;
    seen[0] = acc_cnt[0];
    seen[1] = acc_cnt[1];
    req_a[0] = 4'd9; req_b[0] = 4'd4; req_s[0] = 1'b1; req_v[0] = 1'b1;
    wait_acc(0);
    req_v[0] = 1'b0;
    req_a[1] = 4'd2; req_b[1] = 4'd11; req_s[1] = 1'b0; req_v[1] = 1'b1;
    repeat (7) step();
    rsp_ready = 1'b1;
    wait_acc(1);
    req_v[1] = 1'b0;
    drain();

    // Reset during SETTLE: the operation is dropped and Req0 wins next
    seen[0] = acc_cnt[0];
    req_a[0] = 4'd7; req_b[0] = 4'd1; req_s[0] = 1'b0; req_v[0] = 1'b1;
    wait_acc(0);
    req_v[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_mix(8, 1'b1);
    drain();

    // Randomized traffic with random back-pressure
    run_mix(600, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish expected before 500000ns");
    $fatal(1, "global timeout");
  end

endmodule
